// File: rtl/calc_pkg.sv
// Shared constants for the calculator answer engine: opcodes, FSM state
// encoding and the iteration count of the sequential multiplier/divider.
package calc_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ANS_W      = 32;
    localparam int unsigned ITER_COUNT = 16;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/calc_seq_muldiv.sv
// Iterative 16x16 shift-add multiplier and restoring divider, one bit per step.
// Configuration: divider datapath present only when CALC_DIV_EN is defined.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   a, b          operands captured on load (mul: a*b, div: a/b)
//   op_div        select divide (captured on load)
//   load          capture operands, clear iteration counter
//   step          advance one iteration
//   result        value the datapath holds after the current step completes
//                 (combinational look-ahead so the caller can latch it on the
//                 final step edge); mul: product, div: {quotient, remainder}
//   last          current step is the final iteration
module calc_seq_muldiv
    import calc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                op_div,
    input  logic                load,
    input  logic                step,
    output logic [ANS_W-1:0]    result,
    output logic                last
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;

    // Multiply step: add multiplicand when multiplier LSB set, shift right.
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : (DATA_W+1)'(0));
        mul_hi  = mul_sum[DATA_W:1];
        mul_lo  = {mul_sum[0], lo_q[DATA_W-1:1]};
    end

`ifdef CALC_DIV_EN
    logic [DATA_W-1:0] b_q;
    logic              div_q;
    logic [DATA_W:0]   div_sh;
    logic              div_fits;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    // Restoring divide step: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. Remainder always stays below b.
    always_comb begin
        div_sh   = {hi_q, lo_q[DATA_W-1]};
        div_fits = (div_sh >= {1'b0, b_q});
        div_hi   = div_fits ? DATA_W'(div_sh - {1'b0, b_q}) : div_sh[DATA_W-1:0];
        div_lo   = {lo_q[DATA_W-2:0], div_fits};
        hi_d     = div_q ? div_hi : mul_hi;
        lo_d     = div_q ? div_lo : mul_lo;
        result   = div_q ? {div_lo, div_hi} : {mul_hi, mul_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            b_q   <= b;
            div_q <= op_div;
        end
    end

    // Low half starts as the multiplier (mul) or the dividend (div).
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
        end else if (load) begin
            lo_q <= op_div ? a : b;
        end else if (step) begin
            lo_q <= lo_d;
        end
    end
`else
    logic unused_op_div;
    assign unused_op_div = op_div;

    always_comb begin
        hi_d   = mul_hi;
        lo_d   = mul_lo;
        result = {mul_hi, mul_lo};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
        end else if (load) begin
            lo_q <= b;
        end else if (step) begin
            lo_q <= lo_d;
        end
    end
`endif

    // Working operand, high half and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            hi_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            a_q   <= a;
            hi_q  <= '0;
            cnt_q <= '0;
        end else if (step) begin
            hi_q  <= hi_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last = (cnt_q == CNT_W'(ITER_COUNT - 1));

endmodule

// File: rtl/calc_answer_engine.sv
// Calculator answer engine: captures operands/opcode from the switches,
// computes on a rising IN_compute edge and holds the answer for display.
// Configuration: define CALC_DIV_EN to include the divider; otherwise
// opcode 011 reports an error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IN_switches[15:0]        operand / opcode source
//   IN_store_num1/num2/operation  level store strobes (honoured in IDLE)
//   IN_compute               level, high while the answer stage is shown
//   OUT_answer[31:0]         result
//   OUT_valid/busy/error     DONE state, CALC state, div-by-zero/disabled op
module calc_answer_engine
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       IN_switches,
    input  logic              IN_store_num1,
    input  logic              IN_store_num2,
    input  logic              IN_store_operation,
    input  logic              IN_compute,
    output logic [31:0]       OUT_answer,
    output logic              OUT_valid,
    output logic              OUT_busy,
    output logic              OUT_error
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] num1_q;
    logic [DATA_W-1:0] num2_q;
    logic [2:0]        op_q;
    logic              compute_q;
    logic              start;
    logic              div_ok;
    logic [ANS_W-1:0]  alu_result;
    logic [ANS_W-1:0]  answer_d;
    logic              error_d;
    logic              md_load;
    logic              md_step;
    logic [ANS_W-1:0]  md_result;
    logic              md_last;

    assign start = IN_compute & ~compute_q;

`ifdef CALC_DIV_EN
    assign div_ok = (num2_q != '0);
`else
    assign div_ok = 1'b0;
`endif

    // Single-cycle operations.
    always_comb begin
        alu_result = '0;
        case (op_q)
            OP_ADD:  alu_result = ANS_W'({1'b0, num1_q} + {1'b0, num2_q});
            OP_SUB:  alu_result = ANS_W'(num1_q) - ANS_W'(num2_q);
            OP_AND:  alu_result = ANS_W'(num1_q & num2_q);
            OP_OR:   alu_result = ANS_W'(num1_q | num2_q);
            OP_XOR:  alu_result = ANS_W'(num1_q ^ num2_q);
            OP_SHL:  alu_result = ANS_W'(num1_q) << num2_q[3:0];
            default: alu_result = '0;
        endcase
    end

    calc_seq_muldiv u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .a      (num1_q),
        .b      (num2_q),
        .op_div (op_q == OP_DIV),
        .load   (md_load),
        .step   (md_step),
        .result (md_result),
        .last   (md_last)
    );

    // Next-state and answer/error update.
    always_comb begin
        state_d  = state_q;
        answer_d = OUT_answer;
        error_d  = OUT_error;
        md_load  = 1'b0;
        md_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op_q == OP_MUL || (op_q == OP_DIV && div_ok)) begin
                        state_d = ST_CALC;
                        md_load = 1'b1;
                        error_d = 1'b0;
                    end else if (op_q == OP_DIV) begin
                        state_d  = ST_DONE;
                        answer_d = '0;
                        error_d  = 1'b1;
                    end else begin
                        state_d  = ST_DONE;
                        answer_d = alu_result;
                        error_d  = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                // Dropping IN_compute aborts and leaves the old answer in place.
                if (!IN_compute) begin
                    state_d = ST_IDLE;
                end else begin
                    md_step = 1'b1;
                    if (md_last) begin
                        state_d  = ST_DONE;
                        answer_d = md_result;
                    end
                end
            end
            ST_DONE: begin
                if (!IN_compute) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, flags and answer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            compute_q  <= 1'b0;
            OUT_answer <= '0;
            OUT_valid  <= 1'b0;
            OUT_busy   <= 1'b0;
            OUT_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            compute_q  <= IN_compute;
            OUT_answer <= answer_d;
            OUT_valid  <= (state_d == ST_DONE);
            OUT_busy   <= (state_d == ST_CALC);
            OUT_error  <= error_d;
        end
    end

    // Operand capture; a start on the same edge wins over any store.
    always_ff @(posedge clk) begin
        if (rst) begin
            num1_q <= '0;
            num2_q <= '0;
            op_q   <= OP_ADD;
        end else if (state_q == ST_IDLE && !start) begin
            if (IN_store_num1)      num1_q <= IN_switches;
            if (IN_store_num2)      num2_q <= IN_switches;
            if (IN_store_operation) op_q   <= IN_switches[2:0];
        end
    end

endmodule

// File: tb/tb_calc_answer_engine.sv
// Self-checking bench for calc_answer_engine: directed vector table,
// hand-written multi-cycle sequences and randomized ops against a model.
module tb_calc_answer_engine;
    import calc_pkg::*;

`ifdef CALC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        s_n1, s_n2, s_op, compute;
    logic [31:0] answer;
    logic        valid, busy, error;

    calc_answer_engine dut (
        .clk                (clk),
        .rst                (rst),
        .IN_switches        (sw),
        .IN_store_num1      (s_n1),
        .IN_store_num2      (s_n2),
        .IN_store_operation (s_op),
        .IN_compute         (compute),
        .OUT_answer         (answer),
        .OUT_valid          (valid),
        .OUT_busy           (busy),
        .OUT_error          (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ans;

    typedef struct {
        logic [15:0] n1;
        logic [15:0] n2;
        logic [2:0]  op;
        logic [31:0] ans;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic store_ops(input logic [15:0] n1, input logic [15:0] n2, input logic [2:0] op);
        sw = n1; s_n1 = 1'b1; tick; s_n1 = 1'b0;
        sw = n2; s_n2 = 1'b1; tick; s_n2 = 1'b0;
        sw = {13'd0, op}; s_op = 1'b1; tick; s_op = 1'b0;
    endtask

    // Reference behaviour from the arithmetic definition of each opcode.
    function automatic logic [31:0] model_ans(input logic [15:0] n1, input logic [15:0] n2,
                                              input logic [2:0] op);
        int unsigned x, y;
        x = n1;
        y = n2;
        case (op)
            3'd0: return 32'(x + y);
            3'd1: return 32'(x - y);
            3'd2: return 32'(x * y);
            3'd3: begin
                if (!DIV_EN || y == 0) return 32'd0;
                return ((x / y) << 16) | (x % y);
            end
            3'd4: return 32'(x & y);
            3'd5: return 32'(x | y);
            3'd6: return 32'(x ^ y);
            default: return 32'(x << (y % 16));
        endcase
    endfunction

    function automatic bit model_err(input logic [15:0] n2, input logic [2:0] op);
        return (op == 3'd3) && (!DIV_EN || n2 == 16'd0);
    endfunction

    function automatic int model_lat(input logic [15:0] n2, input logic [2:0] op);
        if (op == 3'd2) return 16;
        if (op == 3'd3 && DIV_EN && n2 != 16'd0) return 16;
        return 0;
    endfunction

    // IN_compute is already high; wait (bounded) for valid and check result.
    task automatic wait_done(input logic [31:0] ea, input logic ee, input int el, input string name);
        int cyc = 0;
        int busy_n = 0;
        do begin
            tick;
            cyc++;
            if (busy) busy_n++;
        end while (!valid && cyc < 40);
        check({name, ".latency"}, 32'(cyc - 1), 32'(el));
        check({name, ".busy_edges"}, 32'(busy_n), 32'(el));
        check({name, ".answer"}, answer, ea);
        check({name, ".error"}, {31'd0, error}, {31'd0, ee});
        last_ans = ea;
    endtask

    task automatic release_compute(input string name);
        compute = 1'b0;
        tick;
        check({name, ".valid_after_release"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        store_ops(v.n1, v.n2, v.op);
        compute = 1'b1;
        wait_done(v.ans, v.err, v.lat, name);
        release_compute(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst = 1'b1; sw = '0; s_n1 = 0; s_n2 = 0; s_op = 0; compute = 0;
        last_ans = '0;
        tick; tick;
        rst = 1'b0;
        check("reset.answer", answer, 32'd0);
        check("reset.flags", {29'd0, valid, busy, error}, 32'd0);

        vecs[0]  = '{16'h0005, 16'h0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 0};
        vecs[1]  = '{16'hFFFF, 16'hFFFF, OP_MUL, 32'hFFFE_0001, 1'b0, 16};
        vecs[2]  = '{16'h0001, 16'h0002, OP_SUB, 32'hFFFF_FFFF, 1'b0, 0};
        vecs[3]  = '{16'hFFFF, 16'h0001, OP_ADD, 32'h0001_0000, 1'b0, 0};
        vecs[4]  = '{16'hF0F0, 16'hFF00, OP_AND, 32'h0000_F000, 1'b0, 0};
        vecs[5]  = '{16'hF0F0, 16'hFF00, OP_OR,  32'h0000_FFF0, 1'b0, 0};
        vecs[6]  = '{16'hF0F0, 16'hFF00, OP_XOR, 32'h0000_0FF0, 1'b0, 0};
        vecs[7]  = '{16'h8001, 16'h0013, OP_SHL, 32'h0004_0008, 1'b0, 0};
        vecs[8]  = '{16'h1234, 16'h0000, OP_MUL, 32'h0000_0000, 1'b0, 16};
        vecs[9]  = '{16'd100,  16'h0000, OP_DIV, 32'h0000_0000, 1'b1, 0};
        if (DIV_EN) begin
            vecs[10] = '{16'd100,  16'd7,    OP_DIV, 32'h000E_0002, 1'b0, 16};
            vecs[11] = '{16'hFFFF, 16'h0001, OP_DIV, 32'hFFFF_0000, 1'b0, 16};
        end else begin
            vecs[10] = '{16'd100,  16'd7,    OP_DIV, 32'h0000_0000, 1'b1, 0};
            vecs[11] = '{16'hFFFF, 16'h0001, OP_DIV, 32'h0000_0000, 1'b1, 0};
        end

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Error and answer stay held after leaving DONE.
        store_ops(16'd5, 16'd0, OP_DIV);
        compute = 1'b1;
        wait_done(32'd0, 1'b1, 0, "div0");
        release_compute("div0");
        check("div0.error_held", {31'd0, error}, 32'd1);

        // Abort a multiply at N+5, then a fresh rise runs the full 16 edges.
        store_ops(16'h00FF, 16'h0101, OP_MUL);
        compute = 1'b1;
        tick;
        repeat (4) tick;
        compute = 1'b0;
        tick;
        check("abort.valid", {31'd0, valid}, 32'd0);
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.answer", answer, last_ans);
        compute = 1'b1;
        wait_done(32'h0000_FFFF, 1'b0, 16, "restart");

        // Held high in DONE: no restart; stores are ignored.
        release_compute("restart");
        store_ops(16'd3, 16'd4, OP_MUL);
        compute = 1'b1;
        wait_done(32'd12, 1'b0, 16, "hold");
        sw = 16'h00AA;
        for (int i = 0; i < 3; i++) begin
            s_n1 = 1'b1;
            tick;
            check($sformatf("hold.valid%0d", i), {30'd0, valid, busy}, 32'd2);
            check($sformatf("hold.answer%0d", i), answer, 32'd12);
        end
        s_n1 = 1'b0;
        release_compute("hold");
        check("hold.answer_held", answer, 32'd12);
        compute = 1'b1;
        wait_done(32'd12, 1'b0, 16, "num1_kept");
        release_compute("num1_kept");

        // Start and store on the same edge: store is dropped.
        sw = 16'h0009;
        s_n1 = 1'b1;
        compute = 1'b1;
        wait_done(32'd12, 1'b0, 16, "start_store");
        s_n1 = 1'b0;
        release_compute("start_store");
        compute = 1'b1;
        wait_done(32'd12, 1'b0, 16, "store_ignored");
        release_compute("store_ignored");

        // Reset at N+8 of a divide overrides everything.
        store_ops(16'd100, 16'd7, OP_DIV);
        compute = 1'b1;
        tick;
        repeat (7) tick;
        rst = 1'b1;
        tick;
        check("midrst.answer", answer, 32'd0);
        check("midrst.flags", {29'd0, valid, busy, error}, 32'd0);
        rst = 1'b0;
        compute = 1'b0;
        tick;
        compute = 1'b1;
        wait_done(32'd0, 1'b0, 0, "post_rst_add");
        release_compute("post_rst_add");

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            v.n1  = 16'($urandom);
            v.n2  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            v.op  = 3'($urandom_range(0, 7));
            v.ans = model_ans(v.n1, v.n2, v.op);
            v.err = model_err(v.n2, v.op);
            v.lat = model_lat(v.n2, v.op);
            run_vec(v, $sformatf("rand%0d_op%0d", i, v.op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_answer_engine.md
CALC_ANSWER_ENGINE -- requirements
Module: calc_answer_engine

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: IN_switches  in  16  operand/opcode source (sw[15:0]).
REQ-004 SHALL have: IN_store_num1, IN_store_num2, IN_store_operation  in  1 each  level stage strobes from the stage selector.
REQ-005 SHALL have: IN_compute  in  1  level; high while the answer stage is displayed.
REQ-006 SHALL have: OUT_answer  out  32  result to the seven-seg display answer input.
REQ-007 SHALL have: OUT_valid, OUT_busy, OUT_error  out  1 each  result ready, iterating, divide-by-zero or disabled op.

Function
REQ-008 SHALL load num1<=IN_switches, num2<=IN_switches, op<=IN_switches[2:0] on every edge its strobe is high, but only in state IDLE.
REQ-009 SHALL detect start = IN_compute & ~compute_q (registered previous); act only in IDLE.
REQ-010 SHALL use FSM IDLE, CALC, DONE; encoding 2 bits.
REQ-011 Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 AND, 101 OR, 110 XOR, 111 shl.
REQ-012 Single-cycle ops (000,001,100-111): start at edge N -> DONE with OUT_answer loaded at edge N; OUT_valid=1 after edge N.
REQ-013 add = zero-extended 17-bit sum; sub = num1-num2 as 32-bit two's complement (0x0000_0001-0x0000_0002 = 0xFFFF_FFFF); logic ops zero-extended; shl = {16'h0,num1} << num2[3:0].
REQ-014 mul: start edge N -> CALC, 4-bit counter=0; shift-add one multiplier bit per edge N+1..N+16; DONE with 32-bit product at edge N+16.
REQ-015 div: restoring, same timing as mul; OUT_answer = {quotient[15:0], remainder[15:0]}.
REQ-016 div with num2==0: start edge N -> DONE, OUT_answer=0, OUT_error=1, no CALC.
REQ-017 OUT_busy SHALL equal (state==CALC); OUT_valid SHALL equal (state==DONE).
REQ-018 Operands SHALL be copied into working registers at start; strobes/switch changes during CALC/DONE have no effect.
REQ-019 IN_compute falling in CALC SHALL abort -> IDLE next edge, OUT_valid=0, OUT_answer unchanged from prior value.
REQ-020 IN_compute falling in DONE SHALL -> IDLE; OUT_answer and OUT_error held until next start.
REQ-021 IN_compute held high in DONE SHALL NOT restart; a new low->high edge is required.
REQ-022 Start and a store strobe on the same edge: start uses pre-edge operand values; the store is ignored.

Reset
REQ-023 On rst edge: state=IDLE, num1=num2=0, op=000, compute_q=0, counter=0, OUT_answer=0, OUT_valid=0, OUT_busy=0, OUT_error=0.
REQ-024 rst SHALL override every other input, including mid-CALC.

Configuration
REQ-025 Macro CALC_DIV_EN: defined -> divider datapath per REQ-015/016.
REQ-026 Not defined -> no divider logic; op 011 -> DONE at start edge, OUT_answer=0, OUT_error=1.

Structure
REQ-027 Package calc_pkg SHALL hold the opcode constants, FSM state encoding, and ITER_COUNT=16.
REQ-028 Iterative mul/div datapath SHALL be sub-module calc_seq_muldiv (inputs a, b, op_div, load, step; outputs result[31:0], last); the FSM and single-cycle ops stay in the top.

Verification
REQ-029 num1=0x0005, num2=0x0007, op=001, IN_compute rise -> after 1 edge OUT_answer=0xFFFF_FFFE, valid=1.
REQ-030 num1=0xFFFF, num2=0xFFFF, op=010 -> busy for 16 edges; OUT_answer=0xFFFE_0001 at edge N+16.
REQ-031 num1=100, num2=7, op=011 -> OUT_answer=0x000E_0002; num2=0 -> answer 0, error=1 after 1 edge (and without CALC_DIV_EN: error=1 for any num2).
REQ-032 mul started, IN_compute dropped at edge N+5 -> IDLE, valid=0; new rise restarts a full 16-edge computation.
REQ-033 rst asserted at edge N+8 of a div -> all outputs 0 next edge; IN_store_num1 pulsed during DONE -> num1 unchanged.
